instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fetch.sv | 146 ++++++++++++++
 tb/tb_instr_fetch.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding
// and the default widths / halt opcode used by instr_fetch.
package fetch_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // Default program-counter and instruction widths
    localparam int DEFAULT_PC_W    = 8;
    localparam int DEFAULT_INSTR_W = 16;

    // Instruction word recognised as halt when halt detection is built in
    localparam logic [DEFAULT_INSTR_W-1:0] DEFAULT_HALT_OPCODE = 16'hFFFF;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Drives a registered pc to an external
// combinational program ROM and captures the returned word into a
// single-entry valid/ready output register. Branch redirects flush the
// held instruction and reload pc.
//
// Optional feature: define IFETCH_HALT_DET_EN to make a fetched
// HALT_OPCODE word park the fetcher in HALTED until the next redirect.
// Without the macro HALT_OPCODE is an ordinary instruction and halted is 0.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                 PC_W        = DEFAULT_PC_W,
    parameter int                 INSTR_W     = DEFAULT_INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] code,
    input  logic               branch_valid,
    input  logic [PC_W-1:0]    branch_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    instr_pc,
    output logic               halted
);

`ifdef IFETCH_HALT_DET_EN
    localparam bit HALT_DET_EN = 1'b1;
`else
    localparam bit HALT_DET_EN = 1'b0;
`endif

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
    logic [INSTR_W-1:0] instr_data_q, instr_data_d;
    logic               instr_valid_q, instr_valid_d;
    logic               load;
    logic               halt_hit;

    // A new word is captured only while fetching, not redirecting, and the
    // output register is empty or being drained this cycle.
    assign load = (state_q == ST_FETCH) && run && !branch_valid &&
                  (!instr_valid_q || instr_ready);

    // Halt detection collapses to constant 0 when the feature is not built.
    assign halt_hit = HALT_DET_EN && (code == HALT_OPCODE);

    // Next-state and next-output computation for the fetch controller
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        instr_data_d  = instr_data_q;
        instr_valid_d = instr_valid_q;

        if (branch_valid) begin
            pc_d          = branch_target;
            instr_valid_d = 1'b0;
            if (state_q == ST_HALTED) begin
                state_d = ST_FETCH;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!run) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (load) begin
                instr_data_d  = code;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                if (halt_hit) begin
                    state_d = ST_HALTED;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end else if (instr_valid_q && instr_ready) begin
                instr_valid_d = 1'b0;
            end
        end
    end

    // State and output registers, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_pc_q    <= '0;
            instr_data_q  <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_data_q  <= instr_data_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign pc          = pc_q;
    assign instr_pc    = instr_pc_q;
    assign instr_data  = instr_data_q;
    assign instr_valid = instr_valid_q;

`ifdef IFETCH_HALT_DET_EN
    logic halted_q, halted_d;

    // halted is registered alongside the state so it tracks HALTED exactly
    always_comb begin
        halted_d = (state_d == ST_HALTED);
    end

    // Registered halt indicator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a behavioural fetch model driven by
// the same inputs is compared against the DUT every cycle, plus literal
// checks on the directed scenarios. Honours IFETCH_HALT_DET_EN.
module tb_instr_fetch;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

`ifdef IFETCH_HALT_DET_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_FETCH  = 1;
    localparam int M_HALTED = 2;

    logic               clk;
    logic               rst;
    logic               run;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] code;
    logic               branch_valid;
    logic [PC_W-1:0]    branch_target;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [PC_W-1:0]    instr_pc;
    logic               halted;

    logic [INSTR_W-1:0] rom [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [PC_W-1:0]    m_pc;
    logic               m_valid;
    logic [INSTR_W-1:0] m_data;
    logic [PC_W-1:0]    m_ipc;
    logic               m_halted;
    int                 m_mode;

    instr_fetch #(
        .PC_W(PC_W),
        .INSTR_W(INSTR_W),
        .RESET_PC(8'd0),
        .HALT_OPCODE(16'hFFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .pc(pc),
        .code(code),
        .branch_valid(branch_valid),
        .branch_target(branch_target),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .halted(halted)
    );

    // program ROM: combinational read of the current pc
    assign code = rom[pc];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            logic [7:0] av;
            av = 8'(a);
            if (a <= 9) rom[a] = {4{av[3:0]}};
            else if (a == 10) rom[a] = 16'hFFFF;
            else rom[a] = {av, ~av};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic br,
                                 input logic [PC_W-1:0] tgt, input int cycles);
        run           = r;
        instr_ready   = rdy;
        branch_valid  = br;
        branch_target = tgt;
        repeat (cycles) @(negedge clk);
    endtask

    // Behavioural model: what the fetcher must present after each edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = '0; m_valid = 1'b0; m_data = '0; m_ipc = '0;
            m_halted = 1'b0; m_mode = M_IDLE;
        end else if (branch_valid) begin
            m_pc = branch_target;
            m_valid = 1'b0;
            if (m_mode == M_HALTED) begin
                m_mode = M_FETCH;
                m_halted = 1'b0;
            end
        end else begin
            int old_mode;
            logic take;
            logic [INSTR_W-1:0] word;
            old_mode = m_mode;
            take = (old_mode == M_FETCH) && run && (!m_valid || instr_ready);
            if (old_mode == M_IDLE && run) m_mode = M_FETCH;
            if (old_mode == M_FETCH && !run) m_mode = M_IDLE;
            if (take) begin
                word = rom[m_pc];
                m_data = word;
                m_ipc = m_pc;
                m_valid = 1'b1;
                if (HALT_EN && word == 16'hFFFF) begin
                    m_mode = M_HALTED;
                    m_halted = 1'b1;
                end else begin
                    m_pc = m_pc + 8'd1;
                end
            end else if (m_valid && instr_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare DUT against the model every cycle outside reset
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("pc", 32'(pc), 32'(m_pc));
            checkOutput("instr_valid", 32'(instr_valid), 32'(m_valid));
            checkOutput("halted", 32'(halted), 32'(m_halted));
            if (m_valid) begin
                checkOutput("instr_data", 32'(instr_data), 32'(m_data));
                checkOutput("instr_pc", 32'(instr_pc), 32'(m_ipc));
            end
        end
    end

    task automatic expectWord(input string tag, input logic [PC_W-1:0] ipc, input logic [INSTR_W-1:0] d);
        checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
        checkOutput({tag, "_ipc"}, 32'(instr_pc), 32'(ipc));
        checkOutput({tag, "_data"}, 32'(instr_data), 32'(d));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; instr_ready = 1'b1;
        branch_valid = 1'b0; branch_target = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_data", 32'(instr_data), 32'd0);
        checkOutput("rst_ipc", 32'(instr_pc), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        rst = 1'b0;

        // sequential fetch
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1);
        checkOutput("idle_valid", 32'(instr_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        checkOutput("enter_valid", 32'(instr_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        expectWord("seq0", 8'd0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        expectWord("seq1", 8'd1, 16'h1111);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        expectWord("seq2", 8'd2, 16'h2222);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        expectWord("seq3", 8'd3, 16'h3333);

        // stall three cycles
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 3);
        expectWord("stall", 8'd3, 16'h3333);
        checkOutput("stall_pc", 32'(pc), 32'd4);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        expectWord("unstall", 8'd4, 16'h4444);

        // branch flush
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 4);
        expectWord("pre_br", 8'd2, 16'h2222);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd8, 1);
        checkOutput("br_flush", 32'(instr_valid), 32'd0);
        checkOutput("br_pc", 32'(pc), 32'd8);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        expectWord("br8", 8'd8, 16'h8888);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        expectWord("br9", 8'd9, 16'h9999);

        // halt opcode
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        expectWord("halt_word", 8'd10, 16'hFFFF);
        if (HALT_EN) begin
            checkOutput("halt_flag", 32'(halted), 32'd1);
            checkOutput("halt_pc", 32'(pc), 32'd10);
        end else begin
            checkOutput("nohalt_flag", 32'(halted), 32'd0);
            checkOutput("nohalt_pc", 32'(pc), 32'd11);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 2);
        if (HALT_EN) begin
            checkOutput("halted_idle_valid", 32'(instr_valid), 32'd0);
            checkOutput("halted_pc", 32'(pc), 32'd10);
        end else begin
            expectWord("after11", 8'd12, 16'h0CF3);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd0, 1);
        checkOutput("unhalt_flag", 32'(halted), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        expectWord("unhalt0", 8'd0, 16'h0000);

        // pc wrap
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd255, 1);
        checkOutput("wrap_pc", 32'(pc), 32'd255);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        expectWord("wrap255", 8'd255, 16'hFF00);
        checkOutput("wrap_next_pc", 32'(pc), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1);
        expectWord("wrap0", 8'd0, 16'h0000);

        // async reset in the middle of a stall
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 2);
        expectWord("pre_rst", 8'd0, 16'h0000);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_valid", 32'(instr_valid), 32'd0);
        checkOutput("async_pc", 32'(pc), 32'd0);
        checkOutput("async_data", 32'(instr_data), 32'd0);
        run = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 3);
        checkOutput("post_rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("post_rst_pc", 32'(pc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
